// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback unit: datapath width, register
// address width, writeback source select codes and load funct3 codes.
package writeback_unit_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

endpackage

// File: rtl/writeback_unit_load_align.sv
// load_align: formats a raw aligned memory word into the loaded value.
// Ports:
//   load_data  raw aligned word from data memory
//   addr_lo    byte offset of the load address
//   funct3     load type (LB/LH/LW/LBU/LHU, others take the word)
//   result     sign/zero-extended loaded value
module load_align #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] load_data,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);
  import writeback_unit_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = '0;
    case (addr_lo)
      2'd0:    byte_sel = load_data[7:0];
      2'd1:    byte_sel = load_data[15:8];
      2'd2:    byte_sel = load_data[23:16];
      default: byte_sel = load_data[31:24];
    endcase
    // Misaligned halfword accesses simply use the half picked by addr_lo[1].
    half_sel = addr_lo[1] ? load_data[31:16] : load_data[15:0];
  end

  always_comb begin
    result = load_data;
    case (funct3)
      LB:      result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LH:      result = {{(XLEN-16){half_sel[15]}}, half_sel};
      LBU:     result = {{(XLEN-8){1'b0}}, byte_sel};
      LHU:     result = {{(XLEN-16){1'b0}}, half_sel};
      default: result = load_data;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: register-file write port driver plus pending-write
// scoreboard for decode RAW hazard stalls.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_*                    MEM-stage result and writeback source select
//   id_*                     decode-stage issue request and source/dest regs
//   stall                    combinational decode stall
//   wb_we, wb_rd, wb_data    register-file write port (1-cycle latency)
//   fwd_valid/rd/data        copy of the write port for EX bypass
module writeback_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic            mem_reg_write,
  input  logic [4:0]      mem_rd,
  input  logic [1:0]      mem_wb_sel,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_load_data,
  input  logic [1:0]      mem_addr_lo,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_pc_plus4,
  input  logic            id_issue,
  input  logic            id_reg_write,
  input  logic [4:0]      id_rd,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  output logic            stall,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
);
  import writeback_unit_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]  load_val;
  logic [XLEN-1:0]  wb_src;
  logic [CNT_W-1:0] cnt [NREG];
  logic             sb_inc;

  load_align #(.XLEN(XLEN)) u_load_align (
    .load_data (mem_load_data),
    .addr_lo   (mem_addr_lo),
    .funct3    (mem_funct3),
    .result    (load_val)
  );

  always_comb begin
    wb_src = mem_alu_result;
    case (wb_sel_e'(mem_wb_sel))
      WB_SEL_LOAD: wb_src = load_val;
      WB_SEL_PC4:  wb_src = mem_pc_plus4;
      default:     wb_src = mem_alu_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      wb_we   <= mem_valid & mem_reg_write & (mem_rd != '0);
      wb_rd   <= mem_rd;
      wb_data <= wb_src;
    end
  end

  assign fwd_valid = wb_we;
  assign fwd_rd    = wb_rd;
  assign fwd_data  = wb_data;

  always_comb begin
    stall = (id_use_rs1 & (id_rs1 != '0) & (cnt[id_rs1] != '0))
          | (id_use_rs2 & (id_rs2 != '0) & (cnt[id_rs2] != '0))
          | (id_reg_write & (id_rd != '0) & (cnt[id_rd] == CNT_MAX));
  end

  assign sb_inc = id_issue & ~stall & id_reg_write & (id_rd != '0);

  // Increment and decrement of the same register cancel; a decrement on an
  // empty counter holds at zero rather than wrapping.
  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < NREG; r++) begin
      if (rst || r == 0) begin
        cnt[r] <= '0;
      end else begin
        if (sb_inc && id_rd == REG_ADDR_W'(r) && !(wb_we && wb_rd == REG_ADDR_W'(r)))
          cnt[r] <= cnt[r] + 1'b1;
        else if (wb_we && wb_rd == REG_ADDR_W'(r) && !(sb_inc && id_rd == REG_ADDR_W'(r))
                 && cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    (wb_we && !(sb_inc && id_rd == wb_rd)) |-> (cnt[wb_rd] != '0));

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_result, mem_load_data, mem_pc_plus4;
  logic [1:0]  mem_addr_lo;
  logic [2:0]  mem_funct3;
  logic        id_issue, id_reg_write, id_use_rs1, id_use_rs2;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic        stall, wb_we, fwd_valid;
  logic [4:0]  wb_rd, fwd_rd;
  logic [31:0] wb_data, fwd_data;

  int n_cmp = 0;
  int n_err = 0;

  writeback_unit #(.XLEN(32), .NREG(32), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_addr_lo(mem_addr_lo),
    .mem_funct3(mem_funct3), .mem_pc_plus4(mem_pc_plus4),
    .id_issue(id_issue), .id_reg_write(id_reg_write), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .stall(stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    mem_valid = 0; mem_reg_write = 0; mem_rd = 0; mem_wb_sel = 0;
    mem_alu_result = 0; mem_load_data = 0; mem_pc_plus4 = 0;
    mem_addr_lo = 0; mem_funct3 = 0;
    id_issue = 0; id_reg_write = 0; id_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_use_rs1 = 0; id_use_rs2 = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    id_issue = 1; id_reg_write = 1; id_rd = rd;
    tick();
    id_issue = 0; id_reg_write = 0; id_rd = 0;
  endtask

  task automatic mem_write(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu);
    mem_valid = 1; mem_reg_write = 1; mem_rd = rd; mem_wb_sel = sel; mem_alu_result = alu;
  endtask

  // Load vectors over mem_load_data = 0x80F1_7F82: {addr_lo, funct3, expected}
  logic [1:0]  ld_off [9] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2};
  logic [2:0]  ld_f3  [9] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b000, 3'b101, 3'b011};
  logic [31:0] ld_exp [9] = '{32'hFFFF_FF82, 32'h0000_0080, 32'hFFFF_80F1, 32'h0000_7F82,
                              32'h80F1_7F82, 32'hFFFF_80F1, 32'h0000_007F, 32'h0000_7F82,
                              32'h80F1_7F82};

  initial begin
    clr();
    rst = 1;
    // Reset with live MEM write and decode issue present: both dropped.
    mem_write(5'd3, 2'b00, 32'h0000_DEAD);
    id_issue = 1; id_reg_write = 1; id_rd = 3;
    tick(); tick();
    chk("rst_we", wb_we, 0);
    chk("rst_rd", wb_rd, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_fwd_data", fwd_data, 0);
    rst = 0;
    clr();
    id_use_rs1 = 1; id_rs1 = 3;
    #1 chk("rst_issue_ignored", stall, 0);
    clr();

    // ALU write to x5.
    issue(5'd5);
    mem_write(5'd5, 2'b00, 32'h0000_00A5);
    tick();
    chk("alu_we", wb_we, 1);
    chk("alu_rd", wb_rd, 5);
    chk("alu_data", wb_data, 32'h0000_00A5);
    chk("alu_fwd_valid", fwd_valid, 1);
    chk("alu_fwd_rd", fwd_rd, 5);
    chk("alu_fwd_data", fwd_data, 32'h0000_00A5);
    // Reset mid-stream drops the next MEM write.
    mem_write(5'd5, 2'b00, 32'h0000_0077);
    rst = 1;
    tick();
    chk("midrst_we", wb_we, 0);
    chk("midrst_data", wb_data, 0);
    rst = 0;
    clr();

    // Load formatting, no register write.
    mem_valid = 1; mem_load_data = 32'h80F1_7F82; mem_wb_sel = 2'b01;
    mem_alu_result = 32'h1111_1111;
    for (int i = 0; i < 9; i++) begin
      mem_addr_lo = ld_off[i];
      mem_funct3 = ld_f3[i];
      tick();
      chk($sformatf("load%0d", i), wb_data, ld_exp[i]);
    end
    chk("load_we", wb_we, 0);
    // Reserved select behaves as ALU.
    mem_wb_sel = 2'b11;
    tick();
    chk("sel_rsvd", wb_data, 32'h1111_1111);
    clr();

    // x0 write never asserts we.
    mem_write(5'd0, 2'b00, 32'h0000_0055);
    tick();
    chk("x0_we", wb_we, 0);
    chk("x0_rd", wb_rd, 0);
    chk("x0_data", wb_data, 32'h0000_0055);
    clr();

    // PC+4 link write to x1.
    issue(5'd1);
    mem_write(5'd1, 2'b10, 32'h0000_0BAD);
    mem_pc_plus4 = 32'h0000_0104;
    tick();
    chk("pc4_we", wb_we, 1);
    chk("pc4_rd", wb_rd, 1);
    chk("pc4_data", wb_data, 32'h0000_0104);
    clr();
    tick();

    // RAW hazard on x7.
    issue(5'd7);
    id_use_rs1 = 1; id_rs1 = 7;
    #1 chk("raw_stall", stall, 1);
    // Issue of x10 while stalled must not count.
    id_issue = 1; id_reg_write = 1; id_rd = 10;
    tick();
    id_issue = 0; id_reg_write = 0; id_rd = 0;
    id_rs1 = 0;
    #1 chk("rs1_x0_nostall", stall, 0);
    id_rs1 = 7;
    mem_write(5'd7, 2'b00, 32'h7);
    tick();
    chk("raw_retire_cycle", stall, 1);
    mem_valid = 0; mem_reg_write = 0;
    tick();
    chk("raw_cleared", stall, 0);
    id_use_rs1 = 0; id_use_rs2 = 1; id_rs2 = 10;
    #1 chk("stalled_issue_dropped", stall, 0);
    clr();
    tick();

    // Simultaneous issue and retire on x9 leaves the count at 1.
    issue(5'd9);
    mem_write(5'd9, 2'b00, 32'h9);
    tick();
    mem_valid = 0; mem_reg_write = 0;
    id_issue = 1; id_reg_write = 1; id_rd = 9;
    #1 chk("sim_no_stall", stall, 0);
    tick();
    id_issue = 0; id_reg_write = 0; id_rd = 0;
    id_use_rs1 = 1; id_rs1 = 9;
    #1 chk("sim_cnt_held", stall, 1);
    mem_write(5'd9, 2'b00, 32'h9);
    tick();
    mem_valid = 0; mem_reg_write = 0;
    tick();
    chk("sim_cnt_one", stall, 0);
    clr();

    // Three writes in flight to x4 saturate its counter.
    id_issue = 1; id_reg_write = 1; id_rd = 4;
    tick(); tick();
    chk("sat_two_ok", stall, 0);
    tick();
    chk("sat_stall", stall, 1);
    tick();
    chk("sat_still_stall", stall, 1);
    id_issue = 0; id_reg_write = 0; id_rd = 0;
    id_use_rs1 = 1; id_rs1 = 4;
    mem_write(5'd4, 2'b00, 32'h4);
    tick(); tick(); tick();
    mem_valid = 0; mem_reg_write = 0;
    chk("sat_one_left", stall, 1);
    tick();
    chk("sat_drained", stall, 0);
    clr();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writer side of the register-file write port. Registers the MEM-stage result and selects the writeback source (ALU, aligned load data, PC+4).
- Drives the register-file write port (rd / data / write enable) and a forwarding copy for EX.
- Keeps a per-register pending-write scoreboard that raises a decode stall on RAW hazards against in-flight writes.

Parameters:
XLEN, 32, datapath width
NREG, 32, architectural register count (x0 hard-wired zero)
CNT_W, 2, pending-write counter width per register (max 2^CNT_W-1 in flight per rd)

Ports:
clk  input  1  pipeline clock, all state on posedge
rst  input  1  synchronous, active-high reset
mem_valid  input  1  MEM stage holds a live instruction this cycle
mem_reg_write  input  1  instruction writes rd
mem_rd  input  5  destination register
mem_wb_sel  input  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
mem_alu_result  input  XLEN  ALU result
mem_load_data  input  XLEN  raw aligned word from data memory
mem_addr_lo  input  2  byte offset of load address
mem_funct3  input  3  load type
mem_pc_plus4  input  XLEN  link value
id_issue  input  1  decode issues an instruction this cycle (only honoured when stall=0)
id_reg_write  input  1  issuing instruction writes rd
id_rd  input  5  issuing destination
id_rs1, id_rs2  input  5 each  issuing sources
id_use_rs1, id_use_rs2  input  1 each  source actually read
stall  output  1  combinational decode stall
wb_we  output  1  register-file write enable
wb_rd  output  5  register-file destination
wb_data  output  XLEN  register-file write data
fwd_valid, fwd_rd, fwd_data  output  1/5/XLEN  copy of wb_* for EX bypass

Behaviour:
- Reset: wb_we=0, wb_rd=0, wb_data=0, fwd_* equal wb_*, all pending counters 0. A MEM input present in the reset cycle is dropped. An id_issue in the reset cycle is ignored.
- Latency: 1 cycle. MEM inputs sampled at posedge N appear on wb_* and fwd_* from N until N+1. The register file writes at posedge N+1.
- wb_we = registered (mem_valid & mem_reg_write & mem_rd!=0). An x0 write never asserts wb_we. wb_rd and wb_data are still registered.
- Load formatting: byte = mem_load_data[8*addr_lo +: 8]; half = addr_lo[1] ? [31:16] : [15:0].
- funct3 000 LB sign-extends byte, 001 LH sign-extends half, 010 LW takes the word, 100 LBU zero-extends byte, 101 LHU zero-extends half. Other values take the word.
- Misaligned half (addr_lo[0]=1) uses the half selected by addr_lo[1]; no trap.
- Scoreboard: counter cnt[r], r=1..31; cnt[0] is constant 0.
  - Increment: at posedge when id_issue & !stall & id_reg_write & id_rd!=0 → cnt[id_rd]+1.
  - Decrement: at posedge when wb_we → cnt[wb_rd]-1.
  - Both on the same register in the same cycle → counter unchanged.
  - Decrement on a 0 counter is clamped to 0 (flags an assertion in simulation).
- stall = (id_use_rs1 & id_rs1!=0 & cnt[id_rs1]!=0) | (id_use_rs2 & id_rs2!=0 & cnt[id_rs2]!=0) | (id_reg_write & id_rd!=0 & cnt[id_rd]==max).
  - stall is combinational and does not depend on id_issue.
- A write retiring in cycle N clears the hazard for a read issued in cycle N+1. The register file captures at the edge that ends N and serves reads at the following negedge.
- Scoreboard counters never wrap; saturation is avoided by the stall term above.

Decomposition:
- Shared package: WB_SEL_ALU/LOAD/PC4 encodings, load funct3 constants (LB, LH, LW, LBU, LHU), XLEN, REG_ADDR_W=5.
- Sub-module load_align: combinational, (load_data, addr_lo, funct3) → formatted XLEN value.
- The WB register and the scoreboard stay in writeback_unit.

Test Plan:
- Reset, then ALU write: mem_valid=1, reg_write=1, rd=5, sel=ALU, alu=0x0000_00A5 → next cycle wb_we=1, wb_rd=5, wb_data=0x0000_00A5, fwd equal. Assert rst mid-stream → wb_we=0 next cycle.
- Loads, mem_load_data=0x80F1_7F82: LB off0 → 0xFFFF_FF82; LBU off3 → 0x0000_0080; LH off2 → 0xFFFF_80F1; LHU off0 → 0x0000_7F82; LW → 0x80F1_7F82.
- x0 and PC+4: rd=0, reg_write=1 → wb_we stays 0 and no counter change. sel=PC4, pc_plus4=0x0000_0104, rd=1 → wb_data=0x0000_0104.
- RAW stall: issue rd=7 → cnt[7]=1. Next cycle rs1=7, use_rs1=1 → stall=1. When wb_we with wb_rd=7 retires, stall=0 the following cycle. rs1=0 never stalls.
- Simultaneous issue of rd=9 and retire of wb_rd=9 → cnt[9] unchanged. With CNT_W=2, three issues to rd=4 → stall on a fourth write to rd=4, and cnt[4] stays 3.
- Issue while stall=1 → counters unchanged.
